// File: rtl/mips32_rtype.sv
// Single-cycle R-type MIPS32 execution core: 32x32 register file, funct decoder
// and an ALU built from an add/sub unit, logic unit, comparator and barrel shifter.

module mips32_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic        write_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
    end else if (write_en && (rd != 5'd0)) begin
      registers[rd] <= write_data;
    end
  end

  // r0 is hardwired to zero on the read side as well as never being written
  assign read_data_1 = (rs == 5'd0) ? 32'h0 : registers[rs];
  assign read_data_2 = (rt == 5'd0) ? 32'h0 : registers[rt];
endmodule

module mips32_decoder (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       valid,
  output logic       sel_arith,
  output logic       sel_logic,
  output logic       sel_cmp,
  output logic       sel_shift,
  output logic       sub,
  output logic [1:0] logic_op,
  output logic       cmp_signed,
  output logic       shift_right,
  output logic       shift_arith
);
  always_comb begin
    valid       = 1'b0;
    sel_arith   = 1'b0;
    sel_logic   = 1'b0;
    sel_cmp     = 1'b0;
    sel_shift   = 1'b0;
    sub         = 1'b0;
    logic_op    = 2'd0;
    cmp_signed  = 1'b0;
    shift_right = 1'b0;
    shift_arith = 1'b0;
    if (opcode == 6'b000000) begin
      case (funct)
        6'h20, 6'h21: begin valid = 1'b1; sel_arith = 1'b1; end
        6'h22, 6'h23: begin valid = 1'b1; sel_arith = 1'b1; sub = 1'b1; end
        6'h24: begin valid = 1'b1; sel_logic = 1'b1; logic_op = 2'd0; end
        6'h25: begin valid = 1'b1; sel_logic = 1'b1; logic_op = 2'd1; end
        6'h26: begin valid = 1'b1; sel_logic = 1'b1; logic_op = 2'd2; end
        6'h27: begin valid = 1'b1; sel_logic = 1'b1; logic_op = 2'd3; end
        6'h2A: begin valid = 1'b1; sel_cmp = 1'b1; cmp_signed = 1'b1; end
        6'h2B: begin valid = 1'b1; sel_cmp = 1'b1; end
        6'h00: begin valid = 1'b1; sel_shift = 1'b1; end
        6'h02: begin valid = 1'b1; sel_shift = 1'b1; shift_right = 1'b1; end
        6'h03: begin
          valid = 1'b1; sel_shift = 1'b1; shift_right = 1'b1; shift_arith = 1'b1;
        end
        default: valid = 1'b0;
      endcase
    end
  end
endmodule

module mips32_addsub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum
);
  // Subtraction reuses the adder as a + ~b + 1; wraps modulo 2^32, no overflow flag
  logic [31:0] b_op;
  assign b_op = sub ? ~b : b;
  assign sum  = a + b_op + {31'd0, sub};
endmodule

module mips32_logic_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] y
);
  always_comb begin
    case (op)
      2'd0:    y = a & b;
      2'd1:    y = a | b;
      2'd2:    y = a ^ b;
      default: y = ~(a | b);
    endcase
  end
endmodule

module mips32_comparator (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] y
);
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               lt_s;
  logic               lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);
  assign y    = {31'd0, is_signed ? lt_s : lt_u};
endmodule

module mips32_shifter (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] y
);
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic        fill;
  logic [31:0] src;
  logic [31:0] shifted;

  // Left shifts run through the same right-shifting log stages with bit reversal
  assign fill = right & arith & data[31];
  assign src  = right ? data : rev32(data);

  always_comb begin
    shifted = src;
    for (int i = 0; i < 5; i++) begin
      if (amount[i]) begin
        shifted = (shifted >> (1 << i)) | (fill ? ~(32'hFFFF_FFFF >> (1 << i)) : 32'h0);
      end
    end
  end

  assign y = right ? shifted : rev32(shifted);
endmodule

module mips32_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic        sel_arith,
  input  logic        sel_logic,
  input  logic        sel_cmp,
  input  logic        sel_shift,
  input  logic        sub,
  input  logic [1:0]  logic_op,
  input  logic        cmp_signed,
  input  logic        shift_right,
  input  logic        shift_arith,
  output logic [31:0] y
);
  logic [31:0] arith_y;
  logic [31:0] logic_y;
  logic [31:0] cmp_y;
  logic [31:0] shift_y;

  mips32_addsub u_addsub (
    .a   (a),
    .b   (b),
    .sub (sub),
    .sum (arith_y)
  );

  mips32_logic_unit u_logic (
    .a  (a),
    .b  (b),
    .op (logic_op),
    .y  (logic_y)
  );

  mips32_comparator u_cmp (
    .a         (a),
    .b         (b),
    .is_signed (cmp_signed),
    .y         (cmp_y)
  );

  mips32_shifter u_shift (
    .data   (b),
    .amount (shamt),
    .right  (shift_right),
    .arith  (shift_arith),
    .y      (shift_y)
  );

  // Selects are one-hot; all low (unsupported instruction) yields zero
  assign y = ({32{sel_arith}} & arith_y) |
             ({32{sel_logic}} & logic_y) |
             ({32{sel_cmp}}   & cmp_y)   |
             ({32{sel_shift}} & shift_y);
endmodule

module mips32_rtype (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] result
);
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];

  logic        valid;
  logic        sel_arith;
  logic        sel_logic;
  logic        sel_cmp;
  logic        sel_shift;
  logic        sub;
  logic [1:0]  logic_op;
  logic        cmp_signed;
  logic        shift_right;
  logic        shift_arith;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] alu_y;

  mips32_decoder u_dec (
    .opcode      (opcode),
    .funct       (funct),
    .valid       (valid),
    .sel_arith   (sel_arith),
    .sel_logic   (sel_logic),
    .sel_cmp     (sel_cmp),
    .sel_shift   (sel_shift),
    .sub         (sub),
    .logic_op    (logic_op),
    .cmp_signed  (cmp_signed),
    .shift_right (shift_right),
    .shift_arith (shift_arith)
  );

  mips32_regfile REGG (
    .clk         (clk),
    .reset       (reset),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .write_en    (valid),
    .write_data  (alu_y),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  mips32_alu u_alu (
    .a           (read_data_1),
    .b           (read_data_2),
    .shamt       (shamt),
    .sel_arith   (sel_arith),
    .sel_logic   (sel_logic),
    .sel_cmp     (sel_cmp),
    .sel_shift   (sel_shift),
    .sub         (sub),
    .logic_op    (logic_op),
    .cmp_signed  (cmp_signed),
    .shift_right (shift_right),
    .shift_arith (shift_arith),
    .y           (alu_y)
  );

  assign result = alu_y;
endmodule

// File: tb/tb_mips32_rtype.sv
// Bench for mips32_rtype: fixed vector table, hand-written reset and mid-cycle
// sequences, then random instructions against a behavioural register-file model.

module tb_mips32_rtype;
  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] result;

  mips32_rtype dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] expect_result;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] mdl [32];

  function automatic logic [31:0] enc(input int op, input int rs, input int rt,
                                      input int rd, input int sh, input int fn);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  // Drive an instruction, let it settle, optionally check result, then cross one edge.
  task automatic step(input logic [31:0] ins, input bit do_check, input string name,
                      input logic [31:0] req);
    instruction = ins;
    #1;
    if (do_check) check(name, result, req);
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [31:0] ins);
    step(ins, 1'b0, "", 32'h0);
  endtask

  // or r0, rX, r0 : shows rX on result without writing anything
  task automatic read_reg(input int r, input logic [31:0] req, input string name);
    step(enc(0, r, 0, 0, 0, 'h25), 1'b1, name, req);
  endtask

  // Build a constant in r using only R-type ops; r30 = all ones, r31 = 1 as scratch.
  task automatic load_reg(input int r, input logic [31:0] v);
    exec(enc(0, 0, 0, 30, 0, 'h27));
    exec(enc(0, 0, 30, 31, 31, 'h02));
    exec(enc(0, 0, 0, r, 0, 'h20));
    for (int i = 31; i >= 0; i--) begin
      exec(enc(0, 0, r, r, 1, 'h00));
      if (v[i]) exec(enc(0, r, 31, r, 0, 'h25));
    end
  endtask

  function automatic bit model_supported(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 1'b0;
    case (ins[5:0])
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] ins);
    logic [31:0] a, b;
    int sh;
    a  = mdl[ins[25:21]];
    b  = mdl[ins[20:16]];
    sh = int'(ins[10:6]);
    if (!model_supported(ins)) return 32'h0;
    case (ins[5:0])
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      default: return $unsigned($signed(b) >>> sh);
    endcase
  endfunction

  initial begin
    reset       = 1'b1;
    instruction = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    instruction = enc(0, 4, 5, 6, 0, 'h20);
    #1;
    check("reset_add_zero", result, 32'h0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_reg(4, 32'h0, "reset_r4");
    read_reg(31, 32'h0, "reset_r31");

    load_reg(4, 32'd10);
    load_reg(5, 32'd3);
    load_reg(11, 32'h7FFF_FFFF);
    load_reg(12, 32'd1);
    load_reg(8, 32'hF0F0_F0F0);
    load_reg(9, 32'h0FF0_0FF0);
    load_reg(10, 32'h8000_0001);

    tbl.push_back('{"sub_r16",       32'h0085_8022,            32'd7});
    tbl.push_back('{"read_r16",      enc(0, 16, 0, 0, 0, 'h25), 32'd7});
    tbl.push_back('{"add_no_trap",   enc(0, 11, 12, 6, 0, 'h20), 32'h8000_0000});
    tbl.push_back('{"slt_neg",       enc(0, 6, 12, 7, 0, 'h2A), 32'd1});
    tbl.push_back('{"sltu_big",      enc(0, 6, 12, 7, 0, 'h2B), 32'd0});
    tbl.push_back('{"and",           enc(0, 8, 9, 20, 0, 'h24), 32'h00F0_00F0});
    tbl.push_back('{"or",            enc(0, 8, 9, 20, 0, 'h25), 32'hFFF0_FFF0});
    tbl.push_back('{"xor",           enc(0, 8, 9, 20, 0, 'h26), 32'hFF00_FF00});
    tbl.push_back('{"nor",           enc(0, 8, 9, 20, 0, 'h27), 32'h000F_000F});
    tbl.push_back('{"sll4",          enc(0, 0, 10, 21, 4, 'h00), 32'h0000_0010});
    tbl.push_back('{"srl4",          enc(0, 0, 10, 21, 4, 'h02), 32'h0800_0000});
    tbl.push_back('{"sra4",          enc(0, 0, 10, 21, 4, 'h03), 32'hF800_0000});
    tbl.push_back('{"sll0",          enc(0, 0, 10, 21, 0, 'h00), 32'h8000_0001});
    tbl.push_back('{"add_rd0",       enc(0, 4, 5, 0, 0, 'h20), 32'd13});
    tbl.push_back('{"read_r0",       enc(0, 0, 0, 0, 0, 'h25), 32'd0});
    tbl.push_back('{"funct3f",       enc(0, 4, 5, 4, 0, 'h3F), 32'd0});
    tbl.push_back('{"r4_kept",       enc(0, 4, 0, 0, 0, 'h25), 32'd10});
    tbl.push_back('{"opcode_nz",     enc(1, 4, 5, 5, 0, 'h20), 32'd0});
    tbl.push_back('{"r5_kept",       enc(0, 5, 0, 0, 0, 'h25), 32'd3});
    tbl.push_back('{"r7_sltu_wb",    enc(0, 7, 0, 0, 0, 'h25), 32'd0});
    tbl.push_back('{"subu_wrap",     enc(0, 5, 4, 22, 0, 'h23), 32'hFFFF_FFF9});
    tbl.push_back('{"addu_wrap",     enc(0, 22, 4, 23, 0, 'h21), 32'd3});
    tbl.push_back('{"sra31",         enc(0, 0, 8, 24, 31, 'h03), 32'hFFFF_FFFF});
    tbl.push_back('{"srl31",         enc(0, 0, 8, 24, 31, 'h02), 32'd1});
    tbl.push_back('{"slt_pos",       enc(0, 4, 5, 25, 0, 'h2A), 32'd0});
    tbl.push_back('{"sltu_small",    enc(0, 5, 4, 25, 0, 'h2B), 32'd1});
    tbl.push_back('{"read_r6",       enc(0, 6, 0, 0, 0, 'h25), 32'h8000_0000});

    foreach (tbl[i]) step(tbl[i].instr, 1'b1, tbl[i].name, tbl[i].expect_result);

    // Only the instruction present at the edge is written back
    instruction = enc(0, 4, 5, 13, 0, 'h20);
    #1;
    check("midcycle_first", result, 32'd13);
    #2;
    instruction = enc(0, 4, 5, 14, 0, 'h22);
    #1;
    check("midcycle_second", result, 32'd7);
    @(posedge clk);
    #1;
    read_reg(13, 32'd0, "midcycle_r13_untouched");
    read_reg(14, 32'd7, "midcycle_r14_written");

    // Asynchronous reset in the middle of a cycle
    #2;
    reset = 1'b1;
    #1;
    read_reg(4, 32'd0, "async_reset_r4");
    read_reg(10, 32'd0, "async_reset_r10");
    step(enc(0, 0, 0, 3, 0, 'h27), 1'b1, "nor_during_reset", 32'hFFFF_FFFF);
    #2;
    reset = 1'b0;
    read_reg(3, 32'd0, "no_write_in_reset");
    exec(enc(0, 0, 0, 3, 0, 'h27));
    read_reg(3, 32'hFFFF_FFFF, "write_after_reset");

    // Random phase against the model, starting from a fresh file
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
    for (int r = 1; r <= 8; r++) begin
      logic [31:0] v;
      v = $urandom;
      if (r == 8) v = 32'h8000_0000;
      load_reg(r, v);
      mdl[r] = v;
    end
    mdl[30] = 32'hFFFF_FFFF;
    mdl[31] = 32'd1;

    for (int n = 0; n < 400; n++) begin
      int fns[13];
      int op, fn;
      logic [31:0] ins, req;
      fns = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h03};
      op  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 63)) : 0;
      fn  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : fns[$urandom_range(0, 12)];
      ins = enc(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), fn);
      req = model_result(ins);
      step(ins, 1'b1, "random", req);
      if (model_supported(ins) && ins[15:11] != 5'd0) mdl[ins[15:11]] = req;
    end
    for (int r = 0; r < 32; r++) read_reg(r, mdl[r], "random_final_reg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips32_rtype.md
Name: mips32_rtype

Overview:
- Single-cycle, R-type-only MIPS32 datapath.
- Decodes a 32-bit instruction word and reads rs/rt from a 32x32 register file.
- Executes the funct-selected ALU operation and presents the ALU output on result.
- Writes the ALU output back to rd on the rising clock edge; used standalone as an ALU/register-file execution core.

Parameters:
- None. Data width is fixed at 32 bits; the register file is fixed at 32 entries.

Ports:
- clk  input  1  system clock; register-file writes happen on its rising edge
- reset  input  1  asynchronous, active-high; clears the register file
- instruction  input  32  R-type instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- result  output  32  combinational ALU result for the current instruction

Behaviour:
- Register file: submodule instance REGG with storage array registers[0:31], each 32 bits, so benches can preload via hierarchical $readmemb.
  - Exposes read_data_1 = registers[rs] and read_data_2 = registers[rt].
  - Both reads are combinational and asynchronous.
- Register 0 reads as 0 at all times. Writes to rd=0 are discarded.
- result is purely combinational from instruction and the current register contents. No pipeline and no output register.
  - result is valid within the same cycle that instruction changes.
- Writeback:
  - At posedge clk, registers[rd] <= result, when opcode==6'b000000, funct is a supported code, and rd!=0.
  - A read of the written register reflects the new value after the edge; result then updates combinationally.
- Supported funct codes (A = read_data_1 from rs, B = read_data_2 from rt):
  - 0x20 add, 0x21 addu: A+B, modulo 2^32. No overflow trap and no flag.
  - 0x22 sub, 0x23 subu: A-B, modulo 2^32.
  - 0x24 and: A&B.
  - 0x25 or: A|B.
  - 0x26 xor: A^B.
  - 0x27 nor: ~(A|B).
  - 0x2A slt: 1 if signed A<B, else 0. Zero-extended to 32 bits.
  - 0x2B sltu: 1 if unsigned A<B, else 0.
  - 0x00 sll: B<<shamt.
  - 0x02 srl: B>>shamt, logical.
  - 0x03 sra: B>>>shamt, arithmetic, sign-filled.
- Unsupported funct or opcode!=0: result = 32'h0 and no register write.
- Shift amount comes only from shamt (0..31). A shamt of 0 passes B unchanged.
- Reset:
  - While reset is high, all 32 registers are forced to 0 asynchronously and no write occurs.
  - result then reflects the zeroed file, e.g. 0 for add.
  - Deassertion takes effect at the next posedge.
  - Benches that preload registers hold reset low.
- An instruction change mid-cycle is legal. Only the value present at the rising edge is written.
- Implementation: structural submodules: register file, ALU (add/sub with shared adder, logic unit, comparator, barrel shifter), funct decoder.

Test Plan:
- Preload r4=10, r5=3, then drive instruction=0x00858022 (sub r16,r4,r5): result=7 before the edge; after the posedge r16 reads 7.
- Preload r4=0x7FFFFFFF, r5=1, then add r6,r4,r5 (0x00853020): result=0x80000000, no trap; then slt r7,r6,r5 gives result=1 and sltu r7,r6,r5 gives result=0.
- Preload r8=0xF0F0F0F0, r9=0x0FF00FF0: and=0x00F000F0, or=0xFFF0FFF0, xor=0xFF00FF00, nor=0x000F000F.
- Preload r9=0x80000001, shamt=4: sll gives 0x00000010, srl gives 0x08000000, sra gives 0xF8000000; shamt=0 returns 0x80000001.
- Write with rd=0 (add r0,r4,r5): r0 still reads 0; an unsupported funct 0x3F gives result=0 and no register changes.
- Assert reset mid-sequence after registers are nonzero: all registers read 0 immediately; after deassertion, a write followed by a read back works normally.
